stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  Stopwatch core, directly downstream of the centisecond tick generator.
//  Rising edges of its tick output (one per 10 ms) advance a BCD
//  MM:SS.CC count under start/stop, clear and lap control.
//  Six BCD digits feed the 7-segment display decoders.
//  Single clock domain: tick_in is sampled synchronously on clock, not used as a clock.
// PARAMETERS
//  MAX_MIN   59  highest minute value, 1..99; the count after MAX_MIN:59.99 is the overflow point
//  SATURATE  0   0: wrap to 00:00.00 at overflow; 1: hold at MAX_MIN:59.99 and pause
// PORTS
//  clock       in   1  system clock (50 MHz)
//  reset       in   1  asynchronous, active-high reset
//  tick_in     in   1  centisecond tick square wave from tick generator; each rising edge = 10 ms
//  start_stop  in   1  one-cycle pulse (debounced upstream): start/pause/resume
//  clear       in   1  one-cycle pulse: zero the count (honoured only in PAUSE)
//  lap         in   1  one-cycle pulse: freeze/unfreeze display (honoured only in RUN)
//  cs_o,cs_t   out  4  centiseconds ones/tens (BCD)
//  s_o,s_t     out  4  seconds ones/tens (BCD, tens 0..5)
//  m_o,m_t     out  4  minutes ones/tens (BCD)
//  running     out  1  1 while FSM in RUN
//  frozen      out  1  1 while display shows latched lap value
//  overflow    out  1  sticky; set at overflow point, cleared by clear or reset
// BEHAVIOUR
//  - Reset (async, any time incl. mid-count): FSM=IDLE; all count, lap and digit outputs 0;
//    running=frozen=overflow=0; tick_q=0.
//  - Edge detect: tick_q <= tick_in each cycle; tick_rise = tick_in & ~tick_q.
//    Count advances on the clock edge where tick_rise=1 and FSM=RUN; outputs show
//    the new value right after that edge. Level-high tick_in does not re-count.
//  - FSM: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN;
//    PAUSE -clear-> IDLE (count zeroed, overflow=0). clear in IDLE/RUN ignored;
//    lap outside RUN ignored.
//  - Increment: BCD ripple carry, cs 00..99 -> s 00..59 -> m 00..MAX_MIN.
//    Each digit resets to 0 when it carries. No binary intermediate.
//  - Overflow point = count MAX_MIN:59.99 plus one tick_rise.
//    SATURATE=0: count -> 00:00.00, overflow=1, stays RUN.
//    SATURATE=1: count holds, overflow=1, FSM -> PAUSE.
//  - Lap, in RUN with frozen=0: latch the current count into lap regs and set frozen=1;
//    the count keeps advancing. Next lap in RUN: frozen=0.
//    frozen=1: outputs = lap regs. frozen=0: outputs = live count.
//    Leaving RUN via start_stop keeps frozen. Entering IDLE forces frozen=0.
//  - Simultaneous, same cycle:
//    tick_rise+start_stop in RUN: tick counted, then PAUSE.
//    tick_rise+start_stop in PAUSE/IDLE: tick not counted, then RUN.
//    start_stop+clear in PAUSE: clear wins -> IDLE.
//    lap+start_stop in RUN: lap applied, then PAUSE.
//    lap+tick_rise in RUN: lap latches the pre-increment count.
//  - running is registered: it equals (FSM==RUN) after each clock edge.
// TESTING
//  1 reset; start_stop; 150 tick rising edges -> digits 00:01.50, running=1, overflow=0
//  2 count at 00:59.99, one tick -> 01:00.00; at 09:59.99 -> 10:00.00 (carry chain)
//  3 MAX_MIN=59, SATURATE=0, preload near 59:59.99, one tick -> 00:00.00, overflow=1, running=1;
//    SATURATE=1 -> holds 59:59.99, overflow=1, running=0
//  4 run to 00:00.25, lap, 30 ticks -> display 00:00.25, frozen=1; lap -> 00:00.55, frozen=0
//  5 pause at 00:02.00, 10 ticks -> unchanged; clear -> IDLE, 00:00.00;
//    clear in RUN -> ignored; start_stop+clear in PAUSE -> IDLE
//  6 tick_in held high 1000 cycles -> exactly 1 count;
//    async reset asserted mid-count at 00:03.17 -> all outputs 0 before next clock edge

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle between the stopwatch core and its surroundings.
// Signalling contract: there is no valid/ready pair here. tick_in is a free-running
// level signal whose rising edges are counted. start_stop, clear and lap are one-cycle
// pulses, sampled on the rising clock edge. All outputs are valid every cycle.
// state_dbg encoding: 0 = IDLE, 1 = RUN, 2 = PAUSE.
interface stopwatch_counter_if;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] cs_o;
    logic [3:0] cs_t;
    logic [3:0] s_o;
    logic [3:0] s_t;
    logic [3:0] m_o;
    logic [3:0] m_t;
    logic       running;
    logic       frozen;
    logic       overflow;
    logic [1:0] state_dbg;

    modport master (
        output tick_in, start_stop, clear, lap,
        input  cs_o, cs_t, s_o, s_t, m_o, m_t, running, frozen, overflow, state_dbg
    );

    modport slave (
        input  tick_in, start_stop, clear, lap,
        output cs_o, cs_t, s_o, s_t, m_o, m_t, running, frozen, overflow, state_dbg
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch core: counts rising edges of the centisecond tick as BCD MM:SS.CC,
// with start/pause, clear and lap-freeze control. Single clock domain.
module stopwatch_counter #(
    parameter int MAX_MIN  = 59,
    parameter bit SATURATE = 1'b0
) (
    input logic               clock,
    input logic               reset,
    stopwatch_counter_if.slave sw
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);
    // Digit order in the packed count: {m_t, m_o, s_t, s_o, cs_t, cs_o}
    localparam logic [23:0] MAX_CNT = {MAX_T, MAX_O, 4'd5, 4'd9, 4'd9, 4'd9};

    state_t      state;
    logic        tick_q;
    logic [23:0] cnt;
    logic [23:0] lap_r;
    logic [23:0] cnt_inc;
    logic [23:0] disp;
    logic        frozen_r;
    logic        running_r;
    logic        overflow_r;
    logic        tick_rise;
    logic        at_max;

    assign tick_rise = sw.tick_in & ~tick_q;
    assign at_max    = (cnt == MAX_CNT);

    // BCD ripple increment: each digit wraps to 0 and passes the carry upward.
    always_comb begin
        logic       carry;
        logic [3:0] lim;
        cnt_inc = cnt;
        carry   = 1'b1;
        lim     = 4'd9;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (carry) begin
                if (cnt[i*4 +: 4] == lim) begin
                    cnt_inc[i*4 +: 4] = 4'd0;
                end else begin
                    cnt_inc[i*4 +: 4] = cnt[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Control FSM, count, lap latch and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_q     <= 1'b0;
            cnt        <= '0;
            lap_r      <= '0;
            frozen_r   <= 1'b0;
            running_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            tick_q <= sw.tick_in;
            case (state)
                IDLE: begin
                    if (sw.start_stop) begin
                        state     <= RUN;
                        running_r <= 1'b1;
                    end
                end
                RUN: begin
                    // Lap latches the pre-increment count even when a tick lands in the same cycle.
                    if (sw.lap) begin
                        if (!frozen_r) begin
                            lap_r    <= cnt;
                            frozen_r <= 1'b1;
                        end else begin
                            frozen_r <= 1'b0;
                        end
                    end
                    if (tick_rise) begin
                        if (at_max) begin
                            overflow_r <= 1'b1;
                            if (SATURATE) begin
                                state     <= PAUSE;
                                running_r <= 1'b0;
                            end else begin
                                cnt <= '0;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    // A simultaneous tick is still counted before pausing.
                    if (sw.start_stop) begin
                        state     <= PAUSE;
                        running_r <= 1'b0;
                    end
                end
                PAUSE: begin
                    // clear has priority over start_stop.
                    if (sw.clear) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        overflow_r <= 1'b0;
                        frozen_r   <= 1'b0;
                    end else if (sw.start_stop) begin
                        state     <= RUN;
                        running_r <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    // Display shows the lap snapshot while frozen, else the live count.
    assign disp         = frozen_r ? lap_r : cnt;
    assign sw.cs_o      = disp[3:0];
    assign sw.cs_t      = disp[7:4];
    assign sw.s_o       = disp[11:8];
    assign sw.s_t       = disp[15:12];
    assign sw.m_o       = disp[19:16];
    assign sw.m_t       = disp[23:20];
    assign sw.running   = running_r;
    assign sw.frozen    = frozen_r;
    assign sw.overflow  = overflow_r;
    assign sw.state_dbg = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: three instances (MAX_MIN=59 wrap, MAX_MIN=1 wrap,
// MAX_MIN=1 saturate) share one stimulus stream and are each compared against an
// integer-centisecond reference model.
module tb_stopwatch_counter;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    stopwatch_counter_if if_a ();
    stopwatch_counter_if if_b ();
    stopwatch_counter_if if_c ();

    stopwatch_counter #(.MAX_MIN(59), .SATURATE(1'b0)) dut_a (.clock(clock), .reset(reset), .sw(if_a));
    stopwatch_counter #(.MAX_MIN(1),  .SATURATE(1'b0)) dut_b (.clock(clock), .reset(reset), .sw(if_b));
    stopwatch_counter #(.MAX_MIN(1),  .SATURATE(1'b1)) dut_c (.clock(clock), .reset(reset), .sw(if_c));

    // ---------------- reference model ----------------
    int max_total [3] = '{59 * 6000 + 5999, 1 * 6000 + 5999, 1 * 6000 + 5999};
    bit sat       [3] = '{1'b0, 1'b0, 1'b1};
    int m_mode    [3];
    int m_count   [3];
    int m_lap     [3];
    bit m_frozen  [3];
    bit m_ovf     [3];
    bit m_prev    [3];

    int checks   = 0;
    int failures = 0;

    function automatic logic [23:0] to_bcd(input int c);
        int cs, s, m;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = c / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic logic [23:0] exp_dig(input int d);
        return to_bcd(m_frozen[d] ? m_lap[d] : m_count[d]);
    endfunction

    function automatic logic [2:0] exp_flags(input int d);
        return {m_mode[d] == M_RUN, m_frozen[d], m_ovf[d]};
    endfunction

    function automatic logic [23:0] obs_dig(input int d);
        case (d)
            0:       return {if_a.m_t, if_a.m_o, if_a.s_t, if_a.s_o, if_a.cs_t, if_a.cs_o};
            1:       return {if_b.m_t, if_b.m_o, if_b.s_t, if_b.s_o, if_b.cs_t, if_b.cs_o};
            default: return {if_c.m_t, if_c.m_o, if_c.s_t, if_c.s_o, if_c.cs_t, if_c.cs_o};
        endcase
    endfunction

    function automatic logic [2:0] obs_flags(input int d);
        case (d)
            0:       return {if_a.running, if_a.frozen, if_a.overflow};
            1:       return {if_b.running, if_b.frozen, if_b.overflow};
            default: return {if_c.running, if_c.frozen, if_c.overflow};
        endcase
    endfunction

    function automatic logic [1:0] obs_state(input int d);
        case (d)
            0:       return if_a.state_dbg;
            1:       return if_b.state_dbg;
            default: return if_c.state_dbg;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_mode[d]   = M_IDLE;
            m_count[d]  = 0;
            m_lap[d]    = 0;
            m_frozen[d] = 1'b0;
            m_ovf[d]    = 1'b0;
            m_prev[d]   = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input bit tk, input bit ss, input bit clr, input bit lp);
        bit rise;
        rise      = tk && !m_prev[d];
        m_prev[d] = tk;
        if (m_mode[d] == M_IDLE) begin
            if (ss) m_mode[d] = M_RUN;
        end else if (m_mode[d] == M_RUN) begin
            if (lp) begin
                if (!m_frozen[d]) begin
                    m_lap[d]    = m_count[d];
                    m_frozen[d] = 1'b1;
                end else begin
                    m_frozen[d] = 1'b0;
                end
            end
            if (rise) begin
                if (m_count[d] == max_total[d]) begin
                    m_ovf[d] = 1'b1;
                    if (sat[d]) m_mode[d] = M_PAUSE;
                    else        m_count[d] = 0;
                end else begin
                    m_count[d] = m_count[d] + 1;
                end
            end
            if (ss) m_mode[d] = M_PAUSE;
        end else begin
            if (clr) begin
                m_mode[d]   = M_IDLE;
                m_count[d]  = 0;
                m_ovf[d]    = 1'b0;
                m_frozen[d] = 1'b0;
            end else if (ss) begin
                m_mode[d] = M_RUN;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_all(input bit tk, input bit ss, input bit clr, input bit lp);
        if_a.tick_in = tk; if_a.start_stop = ss; if_a.clear = clr; if_a.lap = lp;
        if_b.tick_in = tk; if_b.start_stop = ss; if_b.clear = clr; if_b.lap = lp;
        if_c.tick_in = tk; if_c.start_stop = ss; if_c.clear = clr; if_c.lap = lp;
    endtask

    task automatic step(input bit tk, input bit ss, input bit clr, input bit lp);
        @(negedge clock);
        drive_all(tk, ss, clr, lp);
        for (int d = 0; d < 3; d++) model_step(d, tk, ss, clr, lp);
        @(posedge clock);
        #1;
    endtask

    // Each tick: high for 1-2 cycles, then low for 1-2 cycles.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 2)) step(1'b1, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(1, 2)) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive_all(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_dig(d) !== 24'h000000) begin
                failures++;
                $display("FAIL reset_digits dut%0d got=%h exp=%h", d, obs_dig(d), 24'h000000);
            end
            checks++;
            if (obs_flags(d) !== 3'b000) begin
                failures++;
                $display("FAIL reset_flags dut%0d got=%b exp=%b", d, obs_flags(d), 3'b000);
            end
            checks++;
            if (obs_state(d) !== 2'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%0d exp=0", d, obs_state(d));
            end
        end
    endtask

    task automatic test_basic_count();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(150);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_dig(d) !== 24'h000150) begin
                failures++;
                $display("FAIL basic_digits dut%0d got=%h exp=%h", d, obs_dig(d), 24'h000150);
            end
            checks++;
            if (obs_flags(d) !== 3'b100) begin
                failures++;
                $display("FAIL basic_flags dut%0d got=%b exp=%b", d, obs_flags(d), 3'b100);
            end
        end
    endtask

    task automatic test_carry();
        tick_n(5849);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_dig(d) !== 24'h005999) begin
                failures++;
                $display("FAIL carry_pre dut%0d got=%h exp=%h", d, obs_dig(d), 24'h005999);
            end
        end
        tick_n(1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_dig(d) !== 24'h010000) begin
                failures++;
                $display("FAIL carry_minute dut%0d got=%h exp=%h", d, obs_dig(d), 24'h010000);
            end
        end
    endtask

    task automatic test_overflow();
        tick_n(5999);
        checks++;
        if (obs_dig(1) !== 24'h015999) begin
            failures++;
            $display("FAIL ovf_pre_wrap got=%h exp=%h", obs_dig(1), 24'h015999);
        end
        tick_n(2);
        checks++;
        if (obs_dig(0) !== 24'h020001 || obs_flags(0) !== 3'b100) begin
            failures++;
            $display("FAIL ovf_big got=%h/%b exp=%h/%b", obs_dig(0), obs_flags(0), 24'h020001, 3'b100);
        end
        checks++;
        if (obs_dig(1) !== 24'h000001 || obs_flags(1) !== 3'b101) begin
            failures++;
            $display("FAIL ovf_wrap got=%h/%b exp=%h/%b", obs_dig(1), obs_flags(1), 24'h000001, 3'b101);
        end
        checks++;
        if (obs_dig(2) !== 24'h015999 || obs_flags(2) !== 3'b001) begin
            failures++;
            $display("FAIL ovf_sat got=%h/%b exp=%h/%b", obs_dig(2), obs_flags(2), 24'h015999, 3'b001);
        end
        // Pause the wrapping instances, then clear: overflow must drop.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_dig(1) !== 24'h000000 || obs_flags(1) !== 3'b000) begin
            failures++;
            $display("FAIL ovf_clear got=%h/%b exp=%h/%b", obs_dig(1), obs_flags(1), 24'h000000, 3'b000);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_dig(d) !== exp_dig(d) || obs_flags(d) !== exp_flags(d)) begin
                failures++;
                $display("FAIL ovf_model dut%0d got=%h/%b exp=%h/%b", d, obs_dig(d), obs_flags(d), exp_dig(d), exp_flags(d));
            end
        end
    endtask

    task automatic test_lap();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(25);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tick_n(30);
        checks++;
        if (obs_dig(0) !== 24'h000025 || obs_flags(0) !== 3'b110) begin
            failures++;
            $display("FAIL lap_freeze got=%h/%b exp=%h/%b", obs_dig(0), obs_flags(0), 24'h000025, 3'b110);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_dig(0) !== 24'h000055 || obs_flags(0) !== 3'b100) begin
            failures++;
            $display("FAIL lap_release got=%h/%b exp=%h/%b", obs_dig(0), obs_flags(0), 24'h000055, 3'b100);
        end
    endtask

    task automatic test_pause_clear();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(200);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(10);
        checks++;
        if (obs_dig(0) !== 24'h000200 || obs_flags(0) !== 3'b000) begin
            failures++;
            $display("FAIL pause_hold got=%h/%b exp=%h/%b", obs_dig(0), obs_flags(0), 24'h000200, 3'b000);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_dig(0) !== 24'h000000 || obs_state(0) !== 2'd0) begin
            failures++;
            $display("FAIL pause_clear got=%h/%0d exp=%h/0", obs_dig(0), obs_state(0), 24'h000000);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_dig(0) !== 24'h000003 || obs_flags(0) !== 3'b100) begin
            failures++;
            $display("FAIL run_clear_ignored got=%h/%b exp=%h/%b", obs_dig(0), obs_flags(0), 24'h000003, 3'b100);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_dig(0) !== 24'h000000 || obs_flags(0) !== 3'b000 || obs_state(0) !== 2'd0) begin
            failures++;
            $display("FAIL ss_clear_priority got=%h/%b/%0d exp=%h/%b/0", obs_dig(0), obs_flags(0), obs_state(0), 24'h000000, 3'b000);
        end
    endtask

    task automatic test_tick_level();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (1000) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_dig(0) !== 24'h000001) begin
            failures++;
            $display("FAIL tick_level got=%h exp=%h", obs_dig(0), 24'h000001);
        end
    endtask

    task automatic test_async_reset();
        tick_n(316);
        checks++;
        if (obs_dig(0) !== 24'h000317) begin
            failures++;
            $display("FAIL async_pre got=%h exp=%h", obs_dig(0), 24'h000317);
        end
        // Mid-cycle: 3 time units after the posedge, well before the next one.
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_dig(d) !== 24'h000000 || obs_flags(d) !== 3'b000 || obs_state(d) !== 2'd0) begin
                failures++;
                $display("FAIL async_reset dut%0d got=%h/%b/%0d exp=%h/%b/0", d, obs_dig(d), obs_flags(d), obs_state(d), 24'h000000, 3'b000);
            end
        end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_random();
        bit tk, ss, clr, lp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tk  = 1'($urandom_range(0, 1));
            ss  = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 15) == 0);
            lp  = ($urandom_range(0, 7) == 0);
            step(tk, ss, clr, lp);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs_dig(d) !== exp_dig(d) || obs_flags(d) !== exp_flags(d) ||
                    obs_state(d) !== 2'(m_mode[d])) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL random cyc%0d dut%0d got=%h/%b/%0d exp=%h/%b/%0d", n, d,
                                 obs_dig(d), obs_flags(d), obs_state(d), exp_dig(d), exp_flags(d), m_mode[d]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_all(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_basic_count();
        test_carry();
        test_overflow();
        test_lap();
        test_pause_clear();
        test_tick_level();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
